// File: rtl/adc_pkg.sv
// Shared constants and helpers for the multi-channel ADC sampler.
package adc_pkg;

  // Default converter resolution and the widest supported channel count.
  localparam int ADC_DATA_WIDTH   = 8;
  localparam int ADC_MAX_CHANNELS = 8;

  // Fake-data generator: 8-bit Fibonacci LFSR for x^8+x^6+x^5+x^4+1.
  // Channel k is seeded with ADC_LFSR_SEED + k; taps select bits 7,5,4,3.
  localparam logic [7:0] ADC_LFSR_SEED = 8'h01;
  localparam logic [7:0] ADC_LFSR_TAPS = 8'hB8;

  // What happens to the SI output register in a given cycle.
  typedef enum logic [1:0] {
    SI_HOLD  = 2'd0,
    SI_LOAD  = 2'd1,
    SI_DROP  = 2'd2,
    SI_CLEAR = 2'd3
  } si_action_e;

  // Width of the avg_log2 port: enough bits to express 0..avg_log2_max.
  function automatic int avg_log2_width(input int avg_log2_max);
    return (avg_log2_max < 1) ? 1 : $clog2(avg_log2_max + 1);
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ADC clock divider: programmable-rate clk_o plus the sample strobe that
// fires in the fabric cycle just before each clk_o rising edge.
module adc_clk_div #(
  parameter int CLK_DIV_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CLK_DIV_WIDTH-1:0] decimation_factor,
  output logic                     clk_o,
  output logic                     stb
);

  logic [CLK_DIV_WIDTH-1:0] counter_reg;
  logic [CLK_DIV_WIDTH-1:0] counter_next;
  logic [CLK_DIV_WIDTH-1:0] df_last;
  logic                     clk_div_reg;
  logic                     clk_div_next;
  logic                     df_zero;

  assign df_zero = (decimation_factor == '0);
  assign df_last = decimation_factor - CLK_DIV_WIDTH'(1);

  // Next-state for the half-period counter; the divisor is compared live so
  // a reduced divisor that leaves the counter past the end wraps silently.
  always_comb begin
    counter_next = counter_reg;
    clk_div_next = clk_div_reg;
    if (!enable || df_zero) begin
      counter_next = '0;
      clk_div_next = 1'b0;
    end else if (counter_reg == df_last) begin
      counter_next = '0;
      clk_div_next = ~clk_div_reg;
    end else if (counter_reg > df_last) begin
      counter_next = '0;
    end else begin
      counter_next = counter_reg + CLK_DIV_WIDTH'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      counter_reg <= '0;
      clk_div_reg <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      clk_div_reg <= clk_div_next;
    end
  end

  // Strobe on the last count of the low half; every cycle when bypassed.
  assign stb   = enable && (df_zero || ((counter_reg == df_last) && !clk_div_reg));
  assign clk_o = df_zero ? clk_i : clk_div_reg;

endmodule

// File: rtl/adc_sampler_mc.sv
// Multi-channel ADC front end: shared ADC clock, simultaneous capture of all
// channels, optional per-channel box-car averaging, and an SI ready/ack
// output register with a sticky overrun flag.
// Build option: define ADC_FAKE_EN to replace ADC_data with per-channel
// LFSR test patterns.
module adc_sampler_mc
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH    = ADC_DATA_WIDTH,
  parameter int CHANNELS      = 2,
  parameter int CLK_DIV_WIDTH = 32,
  parameter int AVG_LOG2_MAX  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]         ADC_data,
  output logic                                   ADC_oe,
  output logic                                   clk_o,
  output logic [CHANNELS*DATA_WIDTH-1:0]         SI_data,
  output logic                                   SI_rdy,
  input  logic                                   SI_ack,
  input  logic                                   enable,
  input  logic                                   avg_en,
  input  logic [avg_log2_width(AVG_LOG2_MAX)-1:0] avg_log2,
  input  logic [CLK_DIV_WIDTH-1:0]               decimation_factor,
  output logic                                   overrun,
  input  logic                                   overrun_clr
);

  localparam int N_W   = avg_log2_width(AVG_LOG2_MAX);
  localparam int ACC_W = DATA_WIDTH + AVG_LOG2_MAX;
  // One extra bit so 2^AVG_LOG2_MAX itself is representable for the compare.
  localparam int CNT_W = AVG_LOG2_MAX + 1;

  logic                           stb;
  logic                           avg_en_q_reg;
  logic                           avg_toggle;
  logic [CNT_W-1:0]               win_cnt_reg;
  logic [CNT_W-1:0]               cnt_base;
  logic [CNT_W-1:0]               cnt_inc;
  logic [N_W-1:0]                 n_reg;
  logic [N_W-1:0]                 n_in;
  logic [N_W-1:0]                 n_eff;
  logic                           win_done;
  logic [CHANNELS*DATA_WIDTH-1:0] res_data;
  logic [CHANNELS*DATA_WIDTH-1:0] si_data_reg;
  logic                           si_rdy_reg;
  logic                           overrun_reg;
  si_action_e                     si_action;

  assign ADC_oe = 1'b0;

  adc_clk_div #(
    .CLK_DIV_WIDTH(CLK_DIV_WIDTH)
  ) u_clk_div (
    .clk_i            (clk_i),
    .rst              (rst),
    .enable           (enable),
    .decimation_factor(decimation_factor),
    .clk_o            (clk_o),
    .stb              (stb)
  );

  // ---------------------------------------------------------------------
  // Averaging window control (shared by all channels)
  // ---------------------------------------------------------------------
  assign avg_toggle = (avg_en != avg_en_q_reg);
  assign n_in       = (avg_log2 > N_W'(AVG_LOG2_MAX)) ? N_W'(AVG_LOG2_MAX) : avg_log2;
  // A toggle of avg_en makes this cycle behave as the start of a new window.
  assign cnt_base   = avg_toggle ? '0 : win_cnt_reg;
  assign cnt_inc    = cnt_base + CNT_W'(1);
  // Exponent is taken live on the first strobe of a window, then held.
  assign n_eff      = !avg_en ? '0 : ((cnt_base == '0) ? n_in : n_reg);
  // Plain mode is simply a window of one sample.
  assign win_done   = stb && (cnt_inc == (CNT_W'(1) << n_eff));

  // Window counter and latched exponent; cleared while stopped.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      avg_en_q_reg <= 1'b0;
      win_cnt_reg  <= '0;
      n_reg        <= '0;
    end else begin
      avg_en_q_reg <= avg_en;
      if (!enable) begin
        win_cnt_reg <= '0;
        n_reg       <= '0;
      end else if (stb) begin
        win_cnt_reg <= win_done ? '0 : cnt_inc;
        if (cnt_base == '0) begin
          n_reg <= n_in;
        end
      end else if (avg_toggle) begin
        win_cnt_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel sample source and accumulator
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] sample;
      logic [ACC_W-1:0]      acc_reg;
      logic [ACC_W-1:0]      acc_base;
      logic [ACC_W-1:0]      acc_sum;

`ifdef ADC_FAKE_EN
      logic [7:0] lfsr_reg;
      logic [7:0] lfsr_next;

      assign lfsr_next = {lfsr_reg[6:0], ^(lfsr_reg & ADC_LFSR_TAPS)};
      // The captured value is the one before advancing.
      assign sample    = DATA_WIDTH'(lfsr_reg);

      // Test-pattern generator, stepped once per sample strobe.
      always_ff @(posedge clk_i) begin
        if (rst) begin
          lfsr_reg <= ADC_LFSR_SEED + 8'(gi);
        end else if (stb) begin
          lfsr_reg <= lfsr_next;
        end
      end
`else
      assign sample = ADC_data[gi*DATA_WIDTH +: DATA_WIDTH];
`endif

      assign acc_base = (avg_toggle || !avg_en) ? '0 : acc_reg;
      assign acc_sum  = acc_base + ACC_W'(sample);
      // Division by 2^n is a plain shift on the final sum, truncated.
      assign res_data[gi*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(acc_sum >> n_eff);

      // Running sum; restarts after each completed window.
      always_ff @(posedge clk_i) begin
        if (rst || !enable) begin
          acc_reg <= '0;
        end else if (stb) begin
          acc_reg <= win_done ? '0 : acc_sum;
        end else if (avg_toggle) begin
          acc_reg <= '0;
        end
      end
    end
  endgenerate

`ifdef ADC_FAKE_EN
  // Real converter inputs are not sampled in this build.
  logic unused_adc_data;
  assign unused_adc_data = ^ADC_data;
`endif

  // ---------------------------------------------------------------------
  // SI output register
  // ---------------------------------------------------------------------
  // Decide whether a new result loads, is dropped, or the slot empties.
  always_comb begin
    si_action = SI_HOLD;
    if (win_done) begin
      si_action = (si_rdy_reg && !SI_ack) ? SI_DROP : SI_LOAD;
    end else if (si_rdy_reg && SI_ack) begin
      si_action = SI_CLEAR;
    end
  end

  // Output data/valid and sticky overrun; a new drop beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      si_data_reg <= '0;
      si_rdy_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      case (si_action)
        SI_LOAD: begin
          si_data_reg <= res_data;
          si_rdy_reg  <= 1'b1;
        end
        SI_CLEAR: si_rdy_reg <= 1'b0;
        default: ;
      endcase
      if (si_action == SI_DROP) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign SI_data = si_data_reg;
  assign SI_rdy  = si_rdy_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_adc_sampler_mc.sv
// Directed testbench for adc_sampler_mc (default build: real ADC_data).
module tb_adc_sampler_mc;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ADC_data = '0;
  logic        ADC_oe;
  logic        clk_o;
  logic [15:0] SI_data;
  logic        SI_rdy;
  logic        SI_ack = 1'b0;
  logic        enable = 1'b0;
  logic        avg_en = 1'b0;
  logic [2:0]  avg_log2 = '0;
  logic [31:0] decimation_factor = '0;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  adc_sampler_mc #(
    .DATA_WIDTH(8),
    .CHANNELS(2),
    .CLK_DIV_WIDTH(32),
    .AVG_LOG2_MAX(4)
  ) dut (
    .clk_i            (clk_i),
    .rst              (rst),
    .ADC_data         (ADC_data),
    .ADC_oe           (ADC_oe),
    .clk_o            (clk_o),
    .SI_data          (SI_data),
    .SI_rdy           (SI_rdy),
    .SI_ack           (SI_ack),
    .enable           (enable),
    .avg_en           (avg_en),
    .avg_log2         (avg_log2),
    .decimation_factor(decimation_factor),
    .overrun          (overrun),
    .overrun_clr      (overrun_clr)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one fabric cycle; return just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Two reset cycles; returns with rst low before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int rises;
    int first_c;
    int second_c;
    logic prev_clk;
    logic [15:0] last_data;
    logic [7:0] ch0_v [4];
    logic [7:0] ch1_v [4];

    // ---------------- df = 3, plain, ack held ----------------
    decimation_factor = 32'd3;
    enable = 1'b1;
    SI_ack = 1'b1;
    ADC_data = 16'hA55A;
    do_reset();
    check("rst_rdy", {31'd0, SI_rdy}, 32'd0);
    check("rst_data", {16'd0, SI_data}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_clko", {31'd0, clk_o}, 32'd0);
    check("adc_oe", {31'd0, ADC_oe}, 32'd0);

    pulses = 0; rises = 0; first_c = -1; second_c = -1;
    prev_clk = clk_o; last_data = '0;
    for (int c = 0; c < 36; c++) begin
      tick();
      if (SI_rdy) begin
        pulses++;
        last_data = SI_data;
        if (first_c < 0) first_c = c;
        else if (second_c < 0) second_c = c;
      end
      if (clk_o && !prev_clk) rises++;
      prev_clk = clk_o;
    end
    check("df3_pulses", pulses, 32'd6);
    check("df3_clko_rises", rises, 32'd6);
    check("df3_spacing", second_c - first_c, 32'd6);
    check("df3_first_at", first_c, 32'd2);
    check("df3_data", {16'd0, last_data}, 32'h0000A55A);

    // ---------------- df = 0 ramp ----------------
    decimation_factor = 32'd0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ADC_data = {8'(i * 3 + 100), 8'(i)};
      tick();
      check("ramp_rdy", {31'd0, SI_rdy}, 32'd1);
      check("ramp_data", {16'd0, SI_data}, {16'd0, 8'(i * 3 + 100), 8'(i)});
    end
    check("bypass_clko_hi", {31'd0, clk_o}, 32'd1);
    @(negedge clk_i); #1;
    check("bypass_clko_lo", {31'd0, clk_o}, 32'd0);

    // ---------------- averaging n=2, df=1 ----------------
    decimation_factor = 32'd1;
    avg_en = 1'b1;
    avg_log2 = 3'd2;
    ch0_v[0] = 8'd10; ch0_v[1] = 8'd20; ch0_v[2] = 8'd30; ch0_v[3] = 8'd41;
    ch1_v[0] = 8'd4;  ch1_v[1] = 8'd4;  ch1_v[2] = 8'd4;  ch1_v[3] = 8'd8;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ADC_data = {ch1_v[i], ch0_v[i]};
      tick();
      if (i < 3) begin
        check("avg_partial_rdy", {31'd0, SI_rdy}, 32'd0);
        tick();
        check("avg_partial_rdy2", {31'd0, SI_rdy}, 32'd0);
      end
    end
    check("avg_rdy", {31'd0, SI_rdy}, 32'd1);
    check("avg_data", {16'd0, SI_data}, {16'd0, 8'd5, 8'd25});

    // ---------------- overrun, plain, df=1 ----------------
    avg_en = 1'b0;
    avg_log2 = 3'd0;
    SI_ack = 1'b0;
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      ADC_data = 16'h1000 + 16'(e);
      tick();
    end
    check("ovr_data_kept", {16'd0, SI_data}, 32'h00001001);
    check("ovr_rdy", {31'd0, SI_rdy}, 32'd1);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    tick();  // strobe cycle with a drop: set wins
    check("ovr_set_wins", {31'd0, overrun}, 32'd1);
    tick();  // no strobe: clear takes effect
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    overrun_clr = 1'b0;
    tick();  // strobe, still full: drop again
    check("ovr_reset_again", {31'd0, overrun}, 32'd1);
    SI_ack = 1'b1;
    tick();  // no strobe: ack empties the slot
    check("ack_clears_rdy", {31'd0, SI_rdy}, 32'd0);
    SI_ack = 1'b0;
    ADC_data = 16'h00AB;
    tick();  // strobe into empty slot
    check("reload_rdy", {31'd0, SI_rdy}, 32'd1);
    check("reload_data", {16'd0, SI_data}, 32'h000000AB);

    // ---------------- reset with pending result, then mid-window ----------------
    rst = 1'b1;
    tick();
    check("rst_pend_rdy", {31'd0, SI_rdy}, 32'd0);
    check("rst_pend_data", {16'd0, SI_data}, 32'd0);
    check("rst_pend_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    decimation_factor = 32'd0;
    avg_en = 1'b1;
    avg_log2 = 3'd3;
    SI_ack = 1'b1;
    ADC_data = {8'd250, 8'd200};
    for (int i = 0; i < 5; i++) tick();
    check("mid_win_rdy", {31'd0, SI_rdy}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      ADC_data = {8'd16, 8'(i)};
      tick();
      if (i == 7) check("fresh7_rdy", {31'd0, SI_rdy}, 32'd0);
    end
    check("fresh_rdy", {31'd0, SI_rdy}, 32'd1);
    check("fresh_data", {16'd0, SI_data}, {16'd0, 8'd16, 8'd4});

    // ---------------- exponent clamp: 7 -> 4 ----------------
    avg_log2 = 3'd7;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ADC_data = {8'd32, 8'(i)};
      tick();
      if (i == 14) check("clamp15_rdy", {31'd0, SI_rdy}, 32'd0);
    end
    check("clamp_rdy", {31'd0, SI_rdy}, 32'd1);
    check("clamp_data", {16'd0, SI_data}, {16'd0, 8'd32, 8'd7});

    // ---------------- averaging with n = 0 acts as plain ----------------
    avg_log2 = 3'd0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ADC_data = {8'(200 + i), 8'(50 + i)};
      tick();
      check("n0_data", {16'd0, SI_data}, {16'd0, 8'(200 + i), 8'(50 + i)});
    end

    // ---------------- stopped: no results, clock still forwarded ----------------
    enable = 1'b0;
    avg_en = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ADC_data = 16'h7777;
      tick();
    end
    check("disabled_rdy", {31'd0, SI_rdy}, 32'd0);
    check("disabled_clko", {31'd0, clk_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
